// File: rtl/mrd_stage_fsm.sv
// Frame-level sequencer for the mixed-radix DFT engine: sinks one frame, walks every
// factor stage issuing butterfly commands, then drives the output read-out.
module mrd_stage_fsm #(
    parameter int unsigned PTS_W  = 12,
    parameter int unsigned NF_MAX = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_sop,
    input  logic                    in_eop,
    input  logic [PTS_W-1:0]        dftpts,
    input  logic [2:0]              num_factors,
    input  logic [NF_MAX*3-1:0]     nf,
    input  logic [NF_MAX*PTS_W-1:0] pts_div_nf,
    input  logic [NF_MAX*PTS_W-1:0] twdl_den,
    input  logic                    bf_ready,
    input  logic                    stage_done,
    input  logic                    src_ready,
    output logic [2:0]              state,
    output logic [PTS_W-1:0]        sink_cnt,
    output logic                    bf_valid,
    output logic [2:0]              bf_factor,
    output logic [2:0]              bf_stage,
    output logic [PTS_W-1:0]        bf_idx,
    output logic                    twdl_sop,
    output logic [PTS_W-1:0]        twdl_numrtr,
    output logic [PTS_W-1:0]        twdl_demontr,
    output logic                    src_valid,
    output logic                    src_sop,
    output logic                    src_eop,
    output logic [PTS_W-1:0]        src_cnt,
    output logic                    err
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSink   = 3'd1,
        StStage  = 3'd2,
        StWait   = 3'd3,
        StSource = 3'd4
    } state_e;

    state_e state_q;

    logic [PTS_W-1:0]        pts_q;
    logic [2:0]              nfac_q;
    logic [NF_MAX*3-1:0]     nf_q;
    logic [NF_MAX*PTS_W-1:0] pdn_q;
    logic [NF_MAX*PTS_W-1:0] den_q;

    // Slot views padded to 8 so any 3-bit stage index is safe; missing slots read as den=1.
    logic [2:0]       nf_a  [8];
    logic [PTS_W-1:0] pdn_a [8];
    logic [PTS_W-1:0] den_a [8];

    for (genvar i = 0; i < 8; i++) begin : g_slot
        if (i < NF_MAX) begin : g_used
            assign nf_a[i]  = nf_q[3*i +: 3];
            assign pdn_a[i] = pdn_q[PTS_W*i +: PTS_W];
            assign den_a[i] = den_q[PTS_W*i +: PTS_W];
        end else begin : g_unused
            assign nf_a[i]  = 3'd0;
            assign pdn_a[i] = '0;
            assign den_a[i] = PTS_W'(1);
        end
    end

    logic             nfac_ok;
    logic             last_k;
    logic [2:0]       next_k;
    logic [2:0]       stage_sel;
    logic [PTS_W-1:0] wrap;
    logic [PTS_W-1:0] numrtr_inc;
    logic [PTS_W-1:0] sink_inc;
    logic [PTS_W-1:0] src_inc;
    logic [PTS_W-1:0] pts_m1;
    logic             sop_take;
    logic             sink_last;
    logic             enter_stage;

    assign nfac_ok    = (nfac_q != 3'd0) && (32'(nfac_q) <= NF_MAX);
    assign last_k     = (bf_stage == nfac_q - 3'd1);
    assign next_k     = bf_stage + 3'd1;
    assign stage_sel  = (state_q == StWait) ? next_k : 3'd0;
    // Final stage has no following factor product, so the numerator never leaves 0.
    assign wrap       = last_k ? PTS_W'(1) : den_a[next_k];
    assign numrtr_inc = twdl_numrtr + PTS_W'(1);
    assign sink_inc   = sink_cnt + PTS_W'(1);
    assign src_inc    = src_cnt + PTS_W'(1);
    assign pts_m1     = pts_q - PTS_W'(1);

    assign sop_take    = in_valid && in_sop && (state_q == StIdle || state_q == StSink);
    assign sink_last   = (state_q == StSink) && in_valid && !in_sop && (sink_inc == pts_m1);
    assign enter_stage = (sink_last && nfac_ok) ||
                         ((state_q == StWait) && stage_done && !last_k);

    assign state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pts_q        <= '0;
            nfac_q       <= '0;
            nf_q         <= '0;
            pdn_q        <= '0;
            den_q        <= '0;
            sink_cnt     <= '0;
            bf_valid     <= 1'b0;
            bf_factor    <= '0;
            bf_stage     <= '0;
            bf_idx       <= '0;
            twdl_sop     <= 1'b0;
            twdl_numrtr  <= '0;
            twdl_demontr <= '0;
            src_valid    <= 1'b0;
            src_sop      <= 1'b0;
            src_eop      <= 1'b0;
            src_cnt      <= '0;
            err          <= 1'b0;
        end else begin
            if (sop_take) begin
                pts_q    <= dftpts;
                nfac_q   <= num_factors;
                nf_q     <= nf;
                pdn_q    <= pts_div_nf;
                den_q    <= twdl_den;
                sink_cnt <= '0;
            end
            if (in_valid && state_q != StIdle && state_q != StSink) begin
                err <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (in_valid && in_sop) begin
                        err     <= in_eop;
                        state_q <= StSink;
                    end
                end
                StSink: begin
                    if (in_valid) begin
                        if (in_sop) begin
                            err <= 1'b1;
                        end else begin
                            sink_cnt <= sink_inc;
                            if (sink_last) begin
                                if (!in_eop || !nfac_ok) err <= 1'b1;
                                if (!nfac_ok) state_q <= StIdle;
                            end else if (in_eop) begin
                                err <= 1'b1;
                            end
                        end
                    end
                end
                StStage: begin
                    if (stage_done) err <= 1'b1;
                    if (bf_ready) begin
                        bf_idx      <= bf_idx + PTS_W'(1);
                        twdl_sop    <= 1'b0;
                        twdl_numrtr <= (numrtr_inc == wrap) ? '0 : numrtr_inc;
                        if (bf_idx == pdn_a[bf_stage] - PTS_W'(1)) begin
                            bf_valid <= 1'b0;
                            state_q  <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (stage_done && last_k) begin
                        state_q   <= StSource;
                        src_valid <= 1'b1;
                        src_sop   <= 1'b1;
                        src_eop   <= (pts_m1 == '0);
                        src_cnt   <= '0;
                    end
                end
                StSource: begin
                    if (src_ready) begin
                        if (src_eop) begin
                            state_q   <= StIdle;
                            src_valid <= 1'b0;
                            src_sop   <= 1'b0;
                            src_eop   <= 1'b0;
                            src_cnt   <= '0;
                        end else begin
                            src_cnt <= src_inc;
                            src_sop <= 1'b0;
                            src_eop <= (src_inc == pts_m1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (enter_stage) begin
                state_q      <= StStage;
                bf_valid     <= 1'b1;
                bf_stage     <= stage_sel;
                bf_factor    <= nf_a[stage_sel];
                twdl_demontr <= den_a[stage_sel];
                bf_idx       <= '0;
                twdl_numrtr  <= '0;
                twdl_sop     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mrd_stage_fsm.sv
// Bench for mrd_stage_fsm: table-driven and random frames scored against a frame-level
// model of the expected butterfly command stream and output read-out.
`timescale 1ns/1ps
module tb_mrd_stage_fsm;
    localparam int PTS_W  = 12;
    localparam int NF_MAX = 6;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
    logic [PTS_W-1:0]        dftpts = '0;
    logic [2:0]              num_factors = '0;
    logic [NF_MAX*3-1:0]     nf = '0;
    logic [NF_MAX*PTS_W-1:0] pts_div_nf = '0;
    logic [NF_MAX*PTS_W-1:0] twdl_den = '0;
    logic                    bf_ready = 1'b0, stage_done = 1'b0, src_ready = 1'b0;
    logic [2:0]              state;
    logic [PTS_W-1:0]        sink_cnt;
    logic                    bf_valid;
    logic [2:0]              bf_factor;
    logic [2:0]              bf_stage;
    logic [PTS_W-1:0]        bf_idx;
    logic                    twdl_sop;
    logic [PTS_W-1:0]        twdl_numrtr;
    logic [PTS_W-1:0]        twdl_demontr;
    logic                    src_valid, src_sop, src_eop;
    logic [PTS_W-1:0]        src_cnt;
    logic                    err;

    typedef struct {
        int         nfac;
        logic [17:0] fac;
        int         eop_pos;    // -1: on last sample, -2: never, else that sample index
        int         resop_pos;  // -1: none, else restart after that many+1 samples
        int         exp_err;
        int         rdy;        // ready probability in percent
    } frame_t;

    typedef struct {
        int stg;
        int fac;
        int idx;
        int num;
        int den;
        int sop;
    } cmd_t;

    int     n_vec = 0;
    int     n_bad = 0;
    int     cfg_n;
    int     cfg_m;
    int     cfg_f   [8];
    int     cfg_pdn [8];
    int     cfg_den [8];
    cmd_t   cmd_q [$];
    frame_t tbl [8];

    always #5 clk = ~clk;

    mrd_stage_fsm #(.PTS_W(PTS_W), .NF_MAX(NF_MAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_sop       (in_sop),
        .in_eop       (in_eop),
        .dftpts       (dftpts),
        .num_factors  (num_factors),
        .nf           (nf),
        .pts_div_nf   (pts_div_nf),
        .twdl_den     (twdl_den),
        .bf_ready     (bf_ready),
        .stage_done   (stage_done),
        .src_ready    (src_ready),
        .state        (state),
        .sink_cnt     (sink_cnt),
        .bf_valid     (bf_valid),
        .bf_factor    (bf_factor),
        .bf_stage     (bf_stage),
        .bf_idx       (bf_idx),
        .twdl_sop     (twdl_sop),
        .twdl_numrtr  (twdl_numrtr),
        .twdl_demontr (twdl_demontr),
        .src_valid    (src_valid),
        .src_sop      (src_sop),
        .src_eop      (src_eop),
        .src_cnt      (src_cnt),
        .err          (err)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] pk(input int a, input int b, input int c, input int d,
                                       input int e, input int f);
        return {3'(f), 3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    // Frame model: derive the configuration tables and the full command stream.
    task automatic set_cfg(input frame_t fr);
        int wrap;
        cfg_m = 0;
        cfg_n = 1;
        for (int k = 0; k < 8; k++) cfg_f[k] = 0;
        for (int k = 0; k < NF_MAX; k++) begin
            cfg_f[k] = int'(fr.fac[3*k +: 3]);
            if (cfg_f[k] != 0) begin
                cfg_m++;
                cfg_n *= cfg_f[k];
            end
        end
        for (int k = 0; k < 8; k++) begin
            cfg_pdn[k] = (k < cfg_m) ? cfg_n / cfg_f[k] : 0;
            cfg_den[k] = 1;
            for (int j = k; j < cfg_m; j++) cfg_den[k] *= cfg_f[j];
        end
        dftpts      = PTS_W'(cfg_n);
        num_factors = 3'(fr.nfac);
        nf          = fr.fac;
        for (int k = 0; k < NF_MAX; k++) begin
            pts_div_nf[k*PTS_W +: PTS_W] = PTS_W'(cfg_pdn[k]);
            twdl_den[k*PTS_W +: PTS_W]   = PTS_W'(cfg_den[k]);
        end
        cmd_q.delete();
        for (int k = 0; k < fr.nfac; k++) begin
            wrap = (k == fr.nfac - 1) ? 1 : cfg_den[k+1];
            for (int j = 0; j < cfg_pdn[k]; j++)
                cmd_q.push_back('{k, cfg_f[k], j, j % wrap, cfg_den[k], (j == 0) ? 1 : 0});
        end
    endtask

    task automatic send(input bit sop, input bit eop);
        @(negedge clk);
        in_valid = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        in_valid = 1'b1;
        in_sop   = sop;
        in_eop   = eop;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic run_frame(input frame_t fr);
        int          nsrc, stg, acc, wcnt, wdel;
        bit          stalled, done, prev_done;
        logic [42:0] snap, cur, expv;
        cmd_t        c;
        set_cfg(fr);
        if (fr.resop_pos >= 0) begin
            for (int i = 0; i <= fr.resop_pos; i++) begin
                send(i == 0, 1'b0);
                chk("sink_cnt_pre", sink_cnt, i);
            end
        end
        for (int i = 0; i < cfg_n; i++) begin
            send(i == 0, (fr.eop_pos == -1) ? (i == cfg_n - 1) : (i == fr.eop_pos));
            if (i == 0) begin
                // Configuration must already be latched; garbage on the inputs is harmless.
                dftpts      = 12'($urandom);
                num_factors = 3'($urandom);
                nf          = 18'($urandom);
                pts_div_nf  = 72'({$urandom(), $urandom(), $urandom()});
                twdl_den    = 72'({$urandom(), $urandom(), $urandom()});
                chk("sink_state", state, 1);
                if (fr.resop_pos >= 0) chk("restart_err", err, 1);
            end
            chk("sink_cnt", sink_cnt, i);
        end
        if (fr.nfac == 0) begin
            chk("nofac_state", state, 0);
            chk("nofac_err", err, 1);
            return;
        end
        chk("first_bf_state", state, 2);
        chk("first_bf_valid", bf_valid, 1);

        nsrc = 0; stg = 0; acc = 0; wcnt = 0; wdel = $urandom_range(0, 3);
        stalled = 0; done = 0; prev_done = 0; snap = '0;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            @(negedge clk);
            stage_done = 1'b0;
            bf_ready   = 1'b0;
            src_ready  = 1'b0;
            if (prev_done) chk("stage_latency", (stg < fr.nfac) ? bf_valid : src_valid, 1);
            prev_done = 0;
            cur = {bf_stage, bf_factor, bf_idx, twdl_numrtr, twdl_demontr, twdl_sop};
            if (bf_valid) begin
                if (stalled) chk("bf_hold", cur, snap);
                chk("bf_state", state, 2);
                stalled = 0;
                if ($urandom_range(99) < fr.rdy) begin
                    bf_ready = 1'b1;
                    if (cmd_q.size() == 0) begin
                        chk("bf_extra", 1, 0);
                    end else begin
                        c = cmd_q.pop_front();
                        expv = {3'(c.stg), 3'(c.fac), 12'(c.idx), 12'(c.num), 12'(c.den),
                                1'(c.sop)};
                        chk("bf_cmd", cur, expv);
                        acc++;
                    end
                end else begin
                    stalled = 1;
                    snap = cur;
                end
            end else if (state == 3) begin
                if (wcnt == 0) chk("bf_count", acc, (stg < 8) ? cfg_pdn[stg] : 0);
                if (wcnt >= wdel) begin
                    stage_done = 1'b1;
                    prev_done  = 1;
                    wcnt = 0;
                    acc  = 0;
                    stg++;
                    wdel = $urandom_range(0, 3);
                end else begin
                    wcnt++;
                end
            end else if (src_valid) begin
                chk("src_cnt", src_cnt, nsrc);
                chk("src_sop", src_sop, (nsrc == 0) ? 1 : 0);
                chk("src_eop", src_eop, (nsrc == cfg_n - 1) ? 1 : 0);
                if ($urandom_range(99) < fr.rdy) begin
                    src_ready = 1'b1;
                    if (nsrc == cfg_n - 1) done = 1;
                    nsrc++;
                end
            end
        end
        if (!done) chk("frame_timeout", 0, 1);
        @(posedge clk);
        #1;
        chk("end_state", state, 0);
        chk("end_src_valid", src_valid, 0);
        chk("end_err", err, fr.exp_err);
        chk("cmds_left", cmd_q.size(), 0);
        chk("src_beats", nsrc, cfg_n);
        @(negedge clk);
        bf_ready  = 1'b0;
        src_ready = 1'b0;
    endtask

    task automatic reset_mid();
        set_cfg(tbl[0]);
        for (int i = 0; i < 12; i++) send(i == 0, i == 11);
        @(negedge clk);
        bf_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_state", state, 2);
        chk("pre_reset_idx", bf_idx, 2);
        bf_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outs", |{sink_cnt, bf_valid, bf_factor, bf_stage, bf_idx, twdl_sop,
                                twdl_numrtr, twdl_demontr, src_valid, src_sop, src_eop,
                                src_cnt, err}, 0);
        chk("mid_reset_state", state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_reset_quiet", {state, bf_valid}, 0);
        end
    endtask

    initial begin
        frame_t fr;
        int     prod, m, f, tries;
        tbl[0] = '{2, pk(4, 3, 0, 0, 0, 0), -1, -1, 0, 100};
        tbl[1] = '{3, pk(5, 4, 3, 0, 0, 0), -1, -1, 0, 60};
        tbl[2] = '{2, pk(4, 3, 0, 0, 0, 0),  5, -1, 1, 70};
        tbl[3] = '{2, pk(4, 3, 0, 0, 0, 0), -1,  7, 1, 80};
        tbl[4] = '{2, pk(3, 4, 0, 0, 0, 0), -2, -1, 1, 90};
        tbl[5] = '{6, pk(2, 3, 5, 2, 2, 5), -1, -1, 0, 50};
        tbl[6] = '{0, pk(4, 3, 0, 0, 0, 0), -1, -1, 1, 100};
        tbl[7] = '{4, pk(5, 3, 4, 2, 0, 0), -1, -1, 0, 30};

        #12;
        chk("reset_outs", |{sink_cnt, bf_valid, bf_factor, bf_stage, bf_idx, twdl_sop,
                            twdl_numrtr, twdl_demontr, src_valid, src_sop, src_eop,
                            src_cnt, err}, 0);
        chk("reset_state", state, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 8; t++) run_frame(tbl[t]);

        reset_mid();
        run_frame(tbl[0]);

        for (int r = 0; r < 4; r++) begin
            tries = 0;
            do begin
                m = $urandom_range(2, 4);
                prod = 1;
                fr.fac = '0;
                for (int k = 0; k < m; k++) begin
                    f = $urandom_range(2, 5);
                    fr.fac[3*k +: 3] = 3'(f);
                    prod *= f;
                end
                tries++;
            end while (prod < 12 && tries < 50);
            if (prod < 12) begin
                m = 2;
                fr.fac = pk(4, 3, 0, 0, 0, 0);
            end
            fr.nfac      = m;
            fr.eop_pos   = -1;
            fr.resop_pos = -1;
            fr.exp_err   = 0;
            fr.rdy       = $urandom_range(30, 90);
            run_frame(fr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mrd_stage_fsm.md
Name: mrd_stage_fsm

Overview:
- Frame-level sequencer for the mixed radix DFT engine.
- Counts one input frame into memory, then steps the radix-2/3/4/5 engine through every factor stage.
- For each stage it issues butterfly commands carrying factor, stage and twiddle numerator/denominator, and waits for the stage write-back to finish.
- Finally it drives the output read-out of dftpts samples.

Parameters:
- PTS_W, 12, width of point counts, butterfly indices and twiddle fields
- NF_MAX, 6, number of factor slots in the configuration tables

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample strobe
- in_sop  in  1  first sample of frame
- in_eop  in  1  last sample of frame
- dftpts  in  PTS_W  number of DFT points N (12..1200)
- num_factors  in  3  number of stages (1..NF_MAX)
- nf  in  NF_MAX*3  factor per stage, slot 0 in LSBs
- pts_div_nf  in  NF_MAX*PTS_W  N/Nf[k], butterflies in stage k
- twdl_den  in  NF_MAX*PTS_W  Nf[k]*...*Nf[NF_MAX-1]; unused slots hold 1
- bf_ready  in  1  engine accepts butterfly command
- stage_done  in  1  single-cycle pulse: current stage write-back complete
- src_ready  in  1  downstream accepts output sample
- state  out  3  IDLE=0, SINK=1, STAGE=2, WAIT=3, SOURCE=4
- sink_cnt  out  PTS_W  write index of the current input sample
- bf_valid  out  1  butterfly command valid
- bf_factor  out  3  Nf[k]
- bf_stage  out  3  k
- bf_idx  out  PTS_W  butterfly index within the stage
- twdl_sop  out  1  high with the first butterfly of each stage
- twdl_numrtr  out  PTS_W  twiddle numerator
- twdl_demontr  out  PTS_W  twiddle denominator, twdl_den[k]
- src_valid  out  1  output sample valid
- src_sop  out  1  first output sample
- src_eop  out  1  last output sample
- src_cnt  out  PTS_W  read index of the output sample
- err  out  1  sticky frame error flag

Behaviour:
- Reset values: every output is 0; state=IDLE. Reset mid-operation aborts the frame; the engine sees no further bf_valid.
- Configuration: dftpts, num_factors, nf, pts_div_nf and twdl_den are latched on the accepted in_sop. Later input changes have no effect until the next frame.
- IDLE: on in_valid&in_sop, latch the configuration, set sink_cnt=0, clear err and go to SINK in the same cycle.
- SINK:
  - Each in_valid increments sink_cnt.
  - On the in_valid where sink_cnt==N-1, go to STAGE with k=0.
  - If in_eop is absent on that sample, or in_eop arrives earlier, set err; the frame still completes at the count.
  - in_valid&in_sop inside SINK restarts the frame: re-latch the configuration, sink_cnt=0, set err.
- STAGE:
  - bf_valid=1; bf_stage=k; bf_factor=nf[k]; twdl_demontr=twdl_den[k].
  - Command fields are registered and hold steady while bf_valid&!bf_ready.
  - On bf_valid&bf_ready, bf_idx increments.
  - twdl_numrtr is a wrap counter that advances with bf_idx and wraps to 0 at twdl_den[k+1]. For k=num_factors-1 the wrap value is 1, so twdl_numrtr stays 0.
  - twdl_sop=1 only while bf_idx==0.
  - On the accepted butterfly with bf_idx==pts_div_nf[k]-1: drop bf_valid next cycle and go to WAIT.
- WAIT:
  - On stage_done: if k<num_factors-1, then k++, bf_idx=0, twdl_numrtr=0, go to STAGE. Otherwise go to SOURCE with src_cnt=0.
  - A stage_done seen while in STAGE sets err and is ignored.
- SOURCE:
  - src_valid=1.
  - On src_valid&src_ready, src_cnt increments.
  - src_sop=(src_cnt==0); src_eop=(src_cnt==N-1).
  - Outputs hold while src_ready=0.
  - After the accepted src_eop, go to IDLE.
- in_valid outside IDLE/SINK is dropped and sets err.
- Latency: first bf_valid appears 1 cycle after the last input sample. First src_valid appears 1 cycle after the final stage_done.
- Counters are PTS_W bits with no overflow for N≤1200. A frame with num_factors=0 sets err and returns to IDLE.

Test Plan:
- N=12, factors {4,3}: 12 samples with sop/eop → stage0 issues bf_idx 0..2, factor 4, demontr 12, numrtr 0,1,2; stage1 issues bf_idx 0..3, factor 3, demontr 3, numrtr 0; then 12 src beats, eop at src_cnt 11; err=0.
- N=60, factors {5,4,3}: stage1 twdl_numrtr wraps 0,1,2,0,1,2,… (wrap at 3); twdl_sop exactly once per stage.
- bf_ready toggled randomly: command fields stable while stalled; exactly pts_div_nf[k] accepts per stage.
- in_eop at sample 5 of a 12-point frame → err=1; frame still sinks 12 samples and completes normally.
- Second in_sop at sink_cnt 7 → sink_cnt restarts at 0 and err=1; the new frame completes.
- rst_n asserted during STAGE → all outputs 0, state IDLE; the next full frame runs cleanly with err=0.
